// File: rtl/reference_reader.sv
// sync_fifo: generic first-word-fall-through FIFO; DEPTH must be a power of two.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: pushes while full are dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// reference_reader: sweeps the reference buffer and streams I/Q with last (REFERENCE_READER_LOOP_EN: cyclic + stop).
// Latency: first out_valid two cycles after the first read issue; one sample/cycle when out_ready stays high.
// Backpressure: out_ready low fills a 4-deep FIFO; issues pause once FIFO entries + in-flight reach 4.
module reference_reader #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
`ifdef REFERENCE_READER_LOOP_EN
    input  logic                         stop,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    output logic [index_bits-1:0]        m_axi_raddr,
    input  logic                         s_axi_rready,
    input  logic                         s_axi_rvalid,
    input  logic signed [i_bits-1:0]     i_in,
    input  logic signed [q_bits-1:0]     q_in,
    output logic signed [i_bits-1:0]     out_i,
    output logic signed [q_bits-1:0]     out_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int DAT_W      = 1 + i_bits + q_bits;
    localparam logic [index_bits-1:0] LAST_ADDR = index_bits'(buffer_length - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [index_bits-1:0] addr, addr_nxt;
    logic                 issue;
    logic                 done_nxt;
    logic                 inflight;
    logic                 inflight_last;
    logic                 credit_ok;
    logic                 capture;
    logic [CNT_W-1:0]     fifo_count;
    logic [DAT_W-1:0]     head_dat;

    // Reserve a slot for the word still on its way back so a capture never finds the FIFO full.
    assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                    addr_nxt  = '0;
                end
            end
            READ: begin
                if (s_axi_rready && credit_ok) begin
                    issue = 1'b1;
                    if (addr == LAST_ADDR) begin
`ifdef REFERENCE_READER_LOOP_EN
                        addr_nxt  = '0;
`else
                        state_nxt = DRAIN;
`endif
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
`ifdef REFERENCE_READER_LOOP_EN
                if (stop) state_nxt = DRAIN;
`endif
            end
            DRAIN: begin
                if ((fifo_count == '0) && !inflight) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            m_axi_rready  <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            inflight      <= issue;
            inflight_last <= issue && (addr == LAST_ADDR);
            m_axi_rready  <= (fifo_count < CNT_W'(FIFO_DEPTH));
            done          <= done_nxt;
        end
    end

    assign busy         = (state != IDLE);
    assign m_axi_rvalid = issue;
    assign m_axi_raddr  = addr;
    // A missing rvalid on the return cycle simply loses that word.
    assign capture      = inflight && s_axi_rvalid;

    sync_fifo #(
        .WIDTH (DAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (capture),
        .push_dat ({inflight_last, i_in, q_in}),
        .pop      (out_valid && out_ready),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign {out_last, out_i, out_q} = out_valid ? head_dat : '0;
endmodule

// File: tb/tb_reference_reader.sv
// Randomized bench for reference_reader: behavioural buffer responder, stream monitor and sweep-level model.
module tb_reference_reader;
    localparam int L  = 10;
    localparam int IB = 4;
    localparam int IW = 12;
    localparam int QW = 12;
    localparam int DW = 1 + IW + QW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [IB-1:0] m_axi_raddr;
    logic          s_axi_rready;
    logic          s_axi_rvalid;
    logic [IW-1:0] i_in;
    logic [QW-1:0] q_in;
    logic [IW-1:0] out_i;
    logic [QW-1:0] out_q;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef REFERENCE_READER_LOOP_EN
    logic          stop;
`endif

    reference_reader #(
        .buffer_length (L),
        .index_bits    (IB),
        .i_bits        (IW),
        .q_bits        (QW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef REFERENCE_READER_LOOP_EN
        .stop         (stop),
`endif
        .busy         (busy),
        .done         (done),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axi_raddr  (m_axi_raddr),
        .s_axi_rready (s_axi_rready),
        .s_axi_rvalid (s_axi_rvalid),
        .i_in         (i_in),
        .q_in         (q_in),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // knobs written only by the main process
    int t0 = 1 << 30;
    int or_lo = 0, or_hi = 0, sr_lo = 0, sr_hi = 0, rnd_pct = 0;
    int start2_at = -1, drop_addr = -1, stop_iss = 0, clr_gen = 0;
    logic [IW-1:0] ref_i [L];
    logic [QW-1:0] ref_q [L];

    // written only by the driver
    int cyc = 0;

    // written only by the monitor
    int ncyc = 0, seen_gen = 0;
    logic          pend = 1'b0;
    logic [IB-1:0] paddr = '0;
    int iss_q[$];
    logic [DW-1:0] got_q[$];
    int n_iss, n_pop, n_lost, max_out, first_iss, first_vld, first_pop, last_pop;
    int done_cnt, bad_req, hold_err, frz_err;

    int n_checks = 0, n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input driver and read-buffer responder: data returns the cycle after each request.
    initial begin
        int rel;
        start = 1'b0; s_axi_rready = 1'b0; out_ready = 1'b0;
        s_axi_rvalid = 1'b0; i_in = '0; q_in = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            rel = cyc - t0;
            start        = (rel == 0) || (start2_at > 0 && rel == start2_at);
            s_axi_rready = !(rel >= sr_lo && rel < sr_hi) && ($urandom_range(99) >= rnd_pct);
            out_ready    = !(rel >= or_lo && rel < or_hi) && ($urandom_range(99) >= rnd_pct);
            if (pend) begin
                s_axi_rvalid = (int'(paddr) != drop_addr);
                i_in = ref_i[paddr];
                q_in = ref_q[paddr];
            end else begin
                s_axi_rvalid = ($urandom_range(3) == 0);
                i_in = IW'($urandom);
                q_in = QW'($urandom);
            end
        end
    end

    // Monitor, sampling mid-cycle.
    initial begin
        logic [DW-1:0] cur, held;
        logic hold_pending, prev_srdy;
        logic [IB-1:0] prev_raddr;
        hold_pending = 1'b0; prev_srdy = 1'b1; prev_raddr = '0; held = '0;
`ifdef REFERENCE_READER_LOOP_EN
        stop = 1'b0;
`endif
        forever begin
            @(negedge clk);
            ncyc++;
            if (clr_gen != seen_gen) begin
                iss_q.delete(); got_q.delete();
                n_iss = 0; n_pop = 0; n_lost = 0; max_out = 0;
                first_iss = -1; first_vld = -1; first_pop = -1; last_pop = -1;
                done_cnt = 0; bad_req = 0; hold_err = 0; frz_err = 0;
                hold_pending = 1'b0;
                seen_gen = clr_gen;
            end
            if (pend && int'(paddr) == drop_addr) n_lost++;
            pend  = m_axi_rvalid;
            paddr = m_axi_raddr;
            if (m_axi_rvalid) begin
                iss_q.push_back(int'(m_axi_raddr));
                n_iss++;
                if (first_iss < 0) first_iss = ncyc;
                if (!s_axi_rready) bad_req++;
            end
            if (n_iss - n_pop - n_lost > max_out) max_out = n_iss - n_pop - n_lost;
            if (out_valid && first_vld < 0) first_vld = ncyc;
            cur = {out_last, out_i, out_q};
            if (hold_pending && (!out_valid || cur != held)) hold_err++;
            hold_pending = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                n_pop++;
                if (first_pop < 0) first_pop = ncyc;
                last_pop = ncyc;
            end
            if (done) done_cnt++;
            if (!prev_srdy && !s_axi_rready && m_axi_raddr != prev_raddr) frz_err++;
            prev_srdy  = s_axi_rready;
            prev_raddr = m_axi_raddr;
`ifdef REFERENCE_READER_LOOP_EN
            stop = m_axi_rvalid && ((stop_iss > 0) ? (n_iss == stop_iss) : (int'(m_axi_raddr) == L - 1));
`endif
        end
    end

    task automatic fill_ramp();
        for (int k = 0; k < L; k++) begin
            ref_i[k] = IW'(k);
            ref_q[k] = QW'(-k);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < L; k++) begin
            ref_i[k] = IW'($urandom);
            ref_q[k] = QW'($urandom);
        end
    endtask

    task automatic launch();
        clr_gen++;
        @(negedge clk); #1;
        @(posedge clk); #2;
        t0 = cyc + 1;
    endtask

    // Expected stream: request n reads address n mod L; last marks address L-1; dropped words vanish.
    task automatic run_sweep(input string tag, input int n_issue);
        logic [DW-1:0] exp_q[$];
        int k;
        launch();
        for (k = 0; k < 600 && done_cnt == 0; k++) begin
            @(negedge clk); #1;
        end
        check_val($sformatf("%s done_seen", tag), done_cnt != 0, 1);
        repeat (6) @(negedge clk);
        #1;
        for (int n = 0; n < n_issue; n++)
            if ((n % L) != drop_addr)
                exp_q.push_back({(n % L) == L - 1, ref_i[n % L], ref_q[n % L]});
        check_val($sformatf("%s nsamp", tag), got_q.size(), exp_q.size());
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++)
            check_val($sformatf("%s s%0d", tag, n), got_q[n], exp_q[n]);
        check_val($sformatf("%s done_cnt", tag), done_cnt, 1);
        check_val($sformatf("%s busy_after", tag), busy, 0);
        check_val($sformatf("%s niss", tag), iss_q.size(), n_issue);
        for (int n = 0; n < n_issue && n < iss_q.size(); n++)
            check_val($sformatf("%s addr%0d", tag, n), iss_q[n], n % L);
        check_val($sformatf("%s req_no_rdy", tag), bad_req, 0);
        check_val($sformatf("%s hold", tag), hold_err, 0);
        check_val($sformatf("%s credit", tag), max_out <= 4, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        fill_ramp();
        #3;
        check_val("rst busy", busy, 0);
        check_val("rst done", done, 0);
        check_val("rst rvalid", m_axi_rvalid, 0);
        check_val("rst raddr", m_axi_raddr, 0);
        check_val("rst rready", m_axi_rready, 0);
        check_val("rst out_valid", out_valid, 0);
        check_val("rst out_last", out_last, 0);
        check_val("rst out_i", out_i, 0);
        check_val("rst out_q", out_q, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("idle rready", m_axi_rready, 1);

        run_sweep("single", L);
        check_val("single first_latency", first_vld - first_iss, 2);
        check_val("single back_to_back", last_pop - first_pop, L - 1);

        or_lo = 3; or_hi = 13;
        run_sweep("bp", L);
        check_val("bp outstanding", max_out, 4);
        or_lo = 0; or_hi = 0;

        sr_lo = 4; sr_hi = 9;
        run_sweep("stall", L);
        check_val("stall addr_frozen", frz_err, 0);
        sr_lo = 0; sr_hi = 0;

        start2_at = 5;
        run_sweep("dblstart", L);
        start2_at = -1;

        rnd_pct = 25;
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_sweep($sformatf("rand%0d", r), L);
        end
        rnd_pct = 0;

        drop_addr = $urandom_range(0, L - 2);
        run_sweep("proterr", L);
        drop_addr = -1;

        // Asynchronous reset after four samples have been delivered.
        fill_ramp();
        launch();
        for (k = 0; k < 200 && got_q.size() < 4; k++) begin
            @(negedge clk); #1;
        end
        check_val("midrst reached4", got_q.size() >= 4, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst busy", busy, 0);
        check_val("midrst rvalid", m_axi_rvalid, 0);
        check_val("midrst raddr", m_axi_raddr, 0);
        check_val("midrst rready", m_axi_rready, 0);
        check_val("midrst out_valid", out_valid, 0);
        check_val("midrst out_i", out_i, 0);
        check_val("midrst out_q", out_q, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check_val("midrst no_done", done_cnt, 0);
        check_val("midrst idle", busy, 0);
        run_sweep("after_rst", L);

`ifdef REFERENCE_READER_LOOP_EN
        stop_iss = 23;
        run_sweep("loop", 23);
        stop_iss = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reference_reader.md
Name: reference_reader

Overview:
- Initiator/reader for the reference sample buffer's read interface.
- On `start`, sweeps addresses 0..buffer_length-1 and issues one read request per cycle when credit allows.
- Captures the returned I/Q words, which arrive one cycle after each request, into a 4-entry FIFO.
- Presents them as a valid/ready stream with a last flag to the downstream correlator datapath.

Parameters:
- buffer_length, 10, number of reference samples to read per sweep
- index_bits, 4, address width; must satisfy 2^index_bits >= buffer_length
- i_bits, 12, signed I sample width
- q_bits, 12, signed Q sample width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a sweep when idle, ignored otherwise
- busy  out  1  high from accepted start until the final sample is handed off
- done  out  1  one-cycle pulse after the last sample is accepted downstream
- m_axi_rvalid  out  1  read request valid to buffer
- m_axi_rready  out  1  reader can accept returned data (FIFO not full)
- m_axi_raddr  out  index_bits  read address
- s_axi_rready  in  1  buffer ready; request issued only when high
- s_axi_rvalid  in  1  buffer data valid
- i_in  in  i_bits  signed I from buffer
- q_in  in  q_bits  signed Q from buffer
- out_i  out  i_bits  signed I to downstream
- out_q  out  q_bits  signed Q to downstream
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts
- out_last  out  1  high with the sample for address buffer_length-1

Behaviour:
- Reset (async, rst_n low) values:
  - busy=0, done=0, m_axi_rvalid=0, m_axi_raddr=0, m_axi_rready=0.
  - out_valid=0, out_last=0, out_i=0, out_q=0.
  - FIFO emptied; in-flight flag cleared; state=IDLE.
  - Reset mid-sweep aborts the sweep; no done pulse is produced.
- FSM states IDLE, READ, DRAIN:
  - IDLE: start=1 -> READ; addr=0; busy=1 on the next cycle.
  - READ: a request is issued (m_axi_rvalid=1 for one cycle, m_axi_raddr=addr) when s_axi_rready=1 and fifo_count + inflight < 4.
    - On issue: addr increments.
    - The issue at addr=buffer_length-1 transitions READ -> DRAIN.
    - No wrap in non-loop mode.
  - DRAIN: no requests issued; when FIFO is empty and inflight=0 -> IDLE, done=1 for 1 cycle, busy=0.
- Capture rules:
  - inflight is set in the cycle after an issue.
  - Data is captured when inflight=1 and s_axi_rvalid=1, with a fixed 1-cycle latency.
  - Captured word = {i_in, q_in}, plus a last bit equal to (issued addr == buffer_length-1).
  - Capture is never dropped; credit accounting guarantees space.
  - inflight=1 with s_axi_rvalid=0 is a protocol error: the word is discarded and the sweep still completes.
- m_axi_rready = (fifo_count < 4), registered.
- FIFO: 4 entries, first-word fall-through.
  - out_valid = (count != 0).
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Full FIFO blocks further issues, not captures.
- Throughput: 1 sample/cycle with out_ready held high; first out_valid 2 cycles after the first issue.
- start while busy is ignored.
- out_i/out_q/out_last hold their values while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: REFERENCE_READER_LOOP_EN
- Defined:
  - Adds input port `stop` (1 bit).
  - In READ, the issue at buffer_length-1 wraps addr to 0 and stays in READ, giving continuous cyclic streaming; out_last still marks each wrap sample.
  - stop=1 (sampled any cycle) -> finish the current address, then DRAIN.
- Undefined:
  - `stop` port absent.
  - Single sweep as above.

Test Plan:
- Single sweep: buffer_length=10, buffer preloaded with I=k, Q=-k; start pulse; out_ready=1.
  - Expected: 10 outputs (k,-k), k=0..9, in order on consecutive cycles.
  - out_last only on k=9; done pulses once; busy low afterwards.
- Backpressure: out_ready=0 for cycles 3-12 of the sweep.
  - Expected: m_axi_rvalid stops after 4 outstanding samples.
  - No sample lost or duplicated; order is preserved after release.
- Buffer not ready: s_axi_rready held 0 for 5 cycles mid-sweep.
  - Expected: m_axi_raddr frozen; no m_axi_rvalid during the stall.
  - Sweep completes with all 10 samples.
- Reset mid-sweep: rst_n low after 4 samples output.
  - Expected: all outputs at reset values immediately (async); no done pulse.
  - A new start yields samples from address 0.
- Start while busy: second start pulse at cycle 5.
  - Expected: ignored; exactly 10 samples and one done.
- LOOP_EN: start, stop asserted after 23 samples.
  - Expected: address sequence 0..9, 0..9, 0..2.
  - out_last on samples 9 and 19; done after the 23rd sample is accepted.
